game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// game_ctrl : tile-reaction game sequencer. Picks a target tile, times the
//             player's reaction window and keeps score, lives and rounds.
// Revision  : 1.0
// ============================================================================
module game_ctrl #(
  parameter int TICK_DIV = 6500000,
  parameter int LIVES    = 3,
  parameter int ROUNDS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic [2:0] board_size,
  input  logic [2:0] lvl,
  input  logic       click,
  input  logic [1:0] click_row,
  input  logic [1:0] click_col,
  output logic [1:0] target_row,
  output logic [1:0] target_col,
  output logic       target_valid,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [5:0] time_left,
  output logic       game_over,
  output logic       menu_rst
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SHOW = 3'd2,
    S_HIT  = 3'd3,
    S_MISS = 3'd4,
    S_OVER = 3'd5
  } state_t;

  localparam int                   c_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [7:0]           c_ROUNDS     = 8'(ROUNDS);
  localparam logic [1:0]           c_LIVES      = 2'(LIVES);
  localparam logic [7:0]           c_LFSR_SEED  = 8'hA5;

  state_t               r_state, w_state_n;
  logic [7:0]           r_lfsr;
  logic [1:0]           r_row, w_row_n;
  logic [1:0]           r_col, w_col_n;
  logic                 r_valid, w_valid_n;
  logic [7:0]           r_score, w_score_n;
  logic [1:0]           r_lives, w_lives_n;
  logic [5:0]           r_time, w_time_n;
  logic                 r_over, w_over_n;
  logic                 r_menu_rst, w_menu_rst_n;
  logic [7:0]           r_round, w_round_n;
  logic [c_PRESC_W-1:0] r_presc, w_presc_n;

  logic       w_lfsr_fb;
  logic [2:0] w_bs;
  logic       w_prop_ok;
  logic [5:0] w_win;
  logic [7:0] w_round_inc;
  logic       w_match;

  // Taps 8,6,5,4 of the polynomial map to bits 7,5,4,3.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  assign w_bs = (board_size < 3'd2) ? 3'd2 : ((board_size > 3'd4) ? 3'd4 : board_size);
  assign w_prop_ok = ({1'b0, r_lfsr[1:0]} < w_bs) && ({1'b0, r_lfsr[3:2]} < w_bs);
  assign w_round_inc = r_round + 8'd1;
  assign w_match = (click_row == r_row) && (click_col == r_col);

  always_comb begin
    case (lvl)
      3'd2:    w_win = 6'd20;
      3'd3:    w_win = 6'd10;
      default: w_win = 6'd30;
    endcase
  end

  // Registered outputs: every output is the next-value of its own register.
  always_comb begin
    w_state_n    = r_state;
    w_row_n      = r_row;
    w_col_n      = r_col;
    w_valid_n    = 1'b0;
    w_score_n    = r_score;
    w_lives_n    = r_lives;
    w_time_n     = 6'd0;
    w_over_n     = 1'b0;
    w_menu_rst_n = 1'b0;
    w_round_n    = r_round;
    w_presc_n    = r_presc;

    if ((r_state != S_IDLE) && !game_start) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (game_start) begin
            w_lives_n = c_LIVES;
            w_score_n = 8'd0;
            w_round_n = 8'd0;
            w_state_n = S_ARM;
          end
        end
        S_ARM: begin
          if (w_prop_ok) begin
            w_row_n   = r_lfsr[1:0];
            w_col_n   = r_lfsr[3:2];
            w_valid_n = 1'b1;
            w_time_n  = w_win;
            w_presc_n = '0;
            w_state_n = S_SHOW;
          end
        end
        S_SHOW: begin
          // A click beats the timeout when both land in the same cycle.
          if (click) begin
            w_state_n = w_match ? S_HIT : S_MISS;
          end else if (r_time == 6'd0) begin
            w_state_n = S_MISS;
          end else begin
            w_valid_n = 1'b1;
            if (r_presc == c_PRESC_LAST) begin
              w_presc_n = '0;
              w_time_n  = r_time - 6'd1;
            end else begin
              w_presc_n = r_presc + 1'b1;
              w_time_n  = r_time;
            end
          end
        end
        S_HIT: begin
          w_score_n = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
          w_round_n = w_round_inc;
          w_over_n  = (w_round_inc == c_ROUNDS);
          w_state_n = w_over_n ? S_OVER : S_ARM;
        end
        S_MISS: begin
          w_lives_n = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
          w_round_n = w_round_inc;
          w_over_n  = (w_lives_n == 2'd0) || (w_round_inc == c_ROUNDS);
          w_state_n = w_over_n ? S_OVER : S_ARM;
        end
        S_OVER: begin
          if (click) begin
            w_menu_rst_n = 1'b1;
            w_state_n    = S_IDLE;
          end else begin
            w_over_n = 1'b1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= c_LFSR_SEED;
      r_row      <= 2'd0;
      r_col      <= 2'd0;
      r_valid    <= 1'b0;
      r_score    <= 8'd0;
      r_lives    <= c_LIVES;
      r_time     <= 6'd0;
      r_over     <= 1'b0;
      r_menu_rst <= 1'b0;
      r_round    <= 8'd0;
      r_presc    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
      r_row      <= w_row_n;
      r_col      <= w_col_n;
      r_valid    <= w_valid_n;
      r_score    <= w_score_n;
      r_lives    <= w_lives_n;
      r_time     <= w_time_n;
      r_over     <= w_over_n;
      r_menu_rst <= w_menu_rst_n;
      r_round    <= w_round_n;
      r_presc    <= w_presc_n;
    end
  end

  assign target_row   = r_row;
  assign target_col   = r_col;
  assign target_valid = r_valid;
  assign score        = r_score;
  assign lives        = r_lives;
  assign time_left    = r_time;
  assign game_over    = r_over;
  assign menu_rst     = r_menu_rst;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_game_ctrl : randomized game sessions checked against a game-level model.
// Revision     : 1.0
// ============================================================================
module tb_game_ctrl;

  localparam int c_TD     = 4;
  localparam int c_LIVES  = 3;
  localparam int c_ROUNDS = 3;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       game_start = 1'b0;
  logic [2:0] board_size = 3'd2;
  logic [2:0] lvl        = 3'd1;
  logic       click      = 1'b0;
  logic [1:0] click_row  = 2'd0;
  logic [1:0] click_col  = 2'd0;
  logic [1:0] target_row, target_col;
  logic       target_valid;
  logic [7:0] score;
  logic [1:0] lives;
  logic [5:0] time_left;
  logic       game_over, menu_rst;

  game_ctrl #(.TICK_DIV(c_TD), .LIVES(c_LIVES), .ROUNDS(c_ROUNDS)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .board_size(board_size),
    .lvl(lvl), .click(click), .click_row(click_row), .click_col(click_col),
    .target_row(target_row), .target_col(target_col), .target_valid(target_valid),
    .score(score), .lives(lives), .time_left(time_left), .game_over(game_over),
    .menu_rst(menu_rst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Game-level model: bookkeeping plus the cycle at which the LFSR was seeded.
  int m_score, m_lives, m_round, base, arm_cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int lfsr_step(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x << 1) | fb) & 255;
  endfunction

  function automatic int lfsr_at(input int c);
    int x;
    x = 165;
    for (int i = 0; i < c - base; i++) x = lfsr_step(x);
    return x;
  endfunction

  function automatic int clamp_bs(input int b);
    return (b < 2) ? 2 : ((b > 4) ? 4 : b);
  endfunction

  function automatic int win_of(input int l);
    return (l == 2) ? 20 : ((l == 3) ? 10 : 30);
  endfunction

  task automatic start_game(input int bs, input int lv);
    board_size = (bs < 0) ? 3'($urandom_range(0, 7)) : 3'(bs);
    lvl        = (lv < 0) ? 3'($urandom_range(0, 7)) : 3'(lv);
    game_start = 1'b1;
    arm_cyc    = cyc + 1;
    m_score    = 0;
    m_lives    = c_LIVES;
    m_round    = 0;
  endtask

  // act: 0 hit, 1 hit, 2 wrong click, 3 timeout, 4 hit on timeout cycle, 5 drop start
  // res: 0 game continues, 1 game over, 2 game left via dropped start / lost sync
  task automatic play_window(input int act_in, input int nbs, input int nlvl, output int res);
    int x, c, bs, w, er, ec, k, kto, n, act, r, wr, wc;
    bit hit, over;
    res = 0;
    bs  = clamp_bs(int'(board_size));
    w   = win_of(int'(lvl));
    c   = arm_cyc;
    x   = lfsr_at(arm_cyc);
    while (!(((x & 3) < bs) && (((x >> 2) & 3) < bs)) && c < arm_cyc + 4000) begin
      x = lfsr_step(x);
      c++;
    end
    er = x & 3;
    ec = (x >> 2) & 3;
    n = 0;
    while (!target_valid && n < 5000) begin
      tick();
      n++;
    end
    if (!target_valid) begin
      check("show_wait", 0, 1);
      res = 2;
      return;
    end
    check("show_entry_cycle", cyc, c + 1);
    check("target_row", int'(target_row), er);
    check("target_col", int'(target_col), ec);
    check("time_left_entry", int'(time_left), w);
    check("score_show", int'(score), m_score);
    check("lives_show", int'(lives), m_lives);
    // Change settings mid-window; they must only apply from the next ARM.
    board_size = (nbs < 0) ? 3'($urandom_range(0, 7)) : 3'(nbs);
    lvl        = (nlvl < 0) ? 3'($urandom_range(0, 7)) : 3'(nlvl);
    act = act_in;
    if (act < 0) begin
      r = $urandom_range(0, 9);
      act = (r < 4) ? 0 : (r < 6) ? 2 : (r < 7) ? 3 : (r < 9) ? 4 : 5;
    end
    kto = w * c_TD;
    hit = 1'b0;
    if (act == 3) begin
      repeat (kto) tick();
      check("time_left_timeout", int'(time_left), 0);
      check("valid_at_timeout", int'(target_valid), 1);
    end else begin
      k = (act == 4) ? kto : $urandom_range(0, kto);
      repeat (k) tick();
      check("time_left", int'(time_left), w - k / c_TD);
      if (act == 5) begin
        game_start = 1'b0;
        tick();
        check("drop_valid", int'(target_valid), 0);
        check("drop_game_over", int'(game_over), 0);
        check("drop_menu_rst", int'(menu_rst), 0);
        check("drop_time_left", int'(time_left), 0);
        check("drop_score", int'(score), m_score);
        check("drop_lives", int'(lives), m_lives);
        res = 2;
        return;
      end
      hit = (act != 2);
      wr = er;
      wc = ec;
      if (!hit) begin
        do begin
          wr = $urandom_range(0, 3);
          wc = $urandom_range(0, 3);
        end while (wr == er && wc == ec);
      end
      click     = 1'b1;
      click_row = 2'(wr);
      click_col = 2'(wc);
    end
    tick();
    click = 1'b0;
    check("valid_after", int'(target_valid), 0);
    check("time_left_after", int'(time_left), 0);
    // A click during HIT/MISS must have no effect.
    click     = 1'($urandom_range(0, 1));
    click_row = 2'($urandom_range(0, 3));
    click_col = 2'($urandom_range(0, 3));
    tick();
    click = 1'b0;
    m_round++;
    if (hit) m_score = (m_score < 255) ? m_score + 1 : 255;
    else     m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    over = hit ? (m_round == c_ROUNDS) : (m_lives == 0 || m_round == c_ROUNDS);
    check("score", int'(score), m_score);
    check("lives", int'(lives), m_lives);
    check("game_over", int'(game_over), over ? 1 : 0);
    arm_cyc = cyc;
    res = over ? 1 : 0;
  endtask

  task automatic leave_over();
    int d;
    d = $urandom_range(1, 5);
    repeat (d) begin
      tick();
      check("over_hold", int'(game_over), 1);
      check("over_valid", int'(target_valid), 0);
      check("over_score", int'(score), m_score);
      check("over_lives", int'(lives), m_lives);
      check("over_no_menu_rst", int'(menu_rst), 0);
    end
    click     = 1'b1;
    click_row = 2'($urandom_range(0, 3));
    click_col = 2'($urandom_range(0, 3));
    tick();
    click = 1'b0;
    check("menu_rst_pulse", int'(menu_rst), 1);
    check("over_cleared", int'(game_over), 0);
    game_start = 1'b0;
    tick();
    check("menu_rst_end", int'(menu_rst), 0);
    check("idle_score", int'(score), m_score);
    check("idle_lives", int'(lives), m_lives);
  endtask

  task automatic run_game(input int bs, input int lv, input int a0, input int a1,
                          input int a2, input int l1, input int l2);
    int res;
    int acts[3];
    int nls[3];
    acts = '{a0, a1, a2};
    nls  = '{l1, l2, -1};
    start_game(bs, lv);
    res = 0;
    for (int i = 0; i < 6 && res == 0; i++)
      play_window((i < 3) ? acts[i] : -1, bs, (i < 3) ? nls[i] : -1, res);
    check("game_ended", (res != 0) ? 1 : 0, 1);
    if (res == 1) leave_over();
    else begin
      game_start = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    int res, n;
    repeat (3) tick();
    check("rst_target_row", int'(target_row), 0);
    check("rst_target_col", int'(target_col), 0);
    check("rst_valid", int'(target_valid), 0);
    check("rst_score", int'(score), 0);
    check("rst_lives", int'(lives), c_LIVES);
    check("rst_time_left", int'(time_left), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_menu_rst", int'(menu_rst), 0);
    rst  = 1'b0;
    base = cyc;
    tick();

    run_game(2, 1, 0, 0, 3, 1, 3);     // two hits at lvl 1, then a lvl-3 timeout
    run_game(2, 1, 4, 2, 2, -1, -1);   // hit on the timeout cycle, then wrong clicks
    run_game(3, 2, 2, 2, 2, -1, -1);   // three misses empty the lives
    run_game(4, 3, 5, -1, -1, -1, -1); // start dropped mid-window
    for (int g = 0; g < 12; g++) run_game(-1, -1, -1, -1, -1, -1, -1);

    // Reset in the middle of a window, with a matching click in the same cycle.
    start_game(3, 2);
    play_window(0, 3, 2, res);
    play_window(2, 3, 2, res);
    n = 0;
    while (!target_valid && n < 5000) begin
      tick();
      n++;
    end
    check("pre_rst_valid", int'(target_valid), 1);
    rst       = 1'b1;
    click     = 1'b1;
    click_row = target_row;
    click_col = target_col;
    tick();
    click = 1'b0;
    check("mid_rst_target_row", int'(target_row), 0);
    check("mid_rst_target_col", int'(target_col), 0);
    check("mid_rst_valid", int'(target_valid), 0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_lives", int'(lives), c_LIVES);
    check("mid_rst_time_left", int'(time_left), 0);
    check("mid_rst_game_over", int'(game_over), 0);
    check("mid_rst_menu_rst", int'(menu_rst), 0);
    rst        = 1'b0;
    game_start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
